data_memory_arbiter: RTL and testbench

Two-requester round-robin arbiter and access sequencer for the single-port 32-word data memory. Port A is the CPU load/store path; port B is the secondary master (debug/DMA loader). It serialises requests, drives the memory's mem_read/mem_write/address/write_data strobes, and returns read data with a done pulse per port. It also rejects out-of-range addresses without touching memory.

---
 rtl/data_memory_arbiter.sv | 122 ++++++++++++
 tb/tb_data_memory_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the single-port data memory.
// One transaction walks IDLE -> ACCESS -> WAIT -> DONE; every output is registered.
module data_memory_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DEPTH      = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_a,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] wdata_a,
   output logic [DATA_WIDTH-1:0] rdata_a,
   output logic                  done_a,
   output logic                  err_a,
   input  logic                  req_b,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] wdata_b,
   output logic [DATA_WIDTH-1:0] rdata_b,
   output logic                  done_b,
   output logic                  err_b,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_result,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   state_t state;
   logic   grant_b;       // port owning the current transaction (1 = B)
   logic   last_grant_b;  // port granted most recently (1 = B)
   logic   lat_we;
   logic   lat_err;

   logic                  pick_b_c;
   logic                  sel_we_c;
   logic [ADDR_WIDTH-1:0] sel_addr_c;
   logic [DATA_WIDTH-1:0] sel_wdata_c;
   logic                  sel_err_c;

   // Arbitration: a lone request wins; a tie goes to the port not granted last.
   always_comb begin
      pick_b_c    = req_b && (!req_a || !last_grant_b);
      sel_we_c    = pick_b_c ? we_b    : we_a;
      sel_addr_c  = pick_b_c ? addr_b  : addr_a;
      sel_wdata_c = pick_b_c ? wdata_b : wdata_a;
      sel_err_c   = (sel_addr_c >= ADDR_WIDTH'(DEPTH));
   end

   // Sequencer: strobes are loaded on acceptance so they are high during ACCESS.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         grant_b        <= 1'b0;
         last_grant_b   <= 1'b1;
         lat_we         <= 1'b0;
         lat_err        <= 1'b0;
         rdata_a        <= '0;
         rdata_b        <= '0;
         done_a         <= 1'b0;
         done_b         <= 1'b0;
         err_a          <= 1'b0;
         err_b          <= 1'b0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_write_data <= '0;
         busy           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_a || req_b) begin
                  state        <= ACCESS;
                  busy         <= 1'b1;
                  grant_b      <= pick_b_c;
                  last_grant_b <= pick_b_c;
                  lat_we       <= sel_we_c;
                  lat_err      <= sel_err_c;
                  // Out-of-range requests never touch the memory bus.
                  if (!sel_err_c) begin
                     mem_read       <= !sel_we_c;
                     mem_write      <= sel_we_c;
                     mem_address    <= sel_addr_c;
                     mem_write_data <= sel_wdata_c;
                  end
               end
            end
            ACCESS: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               state     <= WAIT;
            end
            WAIT: begin
               if (!lat_err && !lat_we) begin
                  if (grant_b) rdata_b <= mem_result;
                  else         rdata_a <= mem_result;
               end
               done_a <= !grant_b;
               done_b <= grant_b;
               err_a  <= !grant_b && lat_err;
               err_b  <= grant_b && lat_err;
               state  <= DONE;
            end
            DONE: begin
               done_a <= 1'b0;
               done_b <= 1'b0;
               err_a  <= 1'b0;
               err_b  <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a 32-word registered-read memory model.
module tb_data_memory_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          req_a, we_a, req_b, we_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] wdata_a, wdata_b;
   logic [DW-1:0] rdata_a, rdata_b;
   logic          done_a, err_a, done_b, err_b;
   logic          mem_read, mem_write, busy;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_write_data;
   logic [DW-1:0] mem_result;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] mem [32];

   data_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(32)) dut (
      .clock(clock), .reset(reset),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .rdata_a(rdata_a), .done_a(done_a), .err_a(err_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .rdata_b(rdata_b), .done_b(done_b), .err_b(err_b),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_result(mem_result), .busy(busy)
   );

   always #5 clock = ~clock;

   // Memory model: synchronous write, registered read one cycle after the strobe.
   always @(posedge clock) begin
      if (mem_write) mem[mem_address[4:0]] <= mem_write_data;
      if (mem_read)  mem_result <= mem[mem_address[4:0]];
   end

   typedef struct {
      logic          ra; logic wa; logic [AW-1:0] aa; logic [DW-1:0] da;
      logic          rb; logic wb; logic [AW-1:0] ab; logic [DW-1:0] db;
      logic          ep;      // expected winner, 1 = B
      logic          erd;     // expected mem_read in ACCESS
      logic          ewr;     // expected mem_write in ACCESS
      logic [AW-1:0] eaddr;
      logic [DW-1:0] ewd;
      logic          eerr;
      logic [DW-1:0] exa;     // rdata_a expected at done
      logic [DW-1:0] exb;     // rdata_b expected at done
   } vec_t;

   vec_t vecs [12];

   function automatic vec_t mk(input logic ra, input logic wa, input logic [AW-1:0] aa,
                               input logic [DW-1:0] da, input logic rb, input logic wb,
                               input logic [AW-1:0] ab, input logic [DW-1:0] db,
                               input logic ep, input logic erd, input logic ewr,
                               input logic [AW-1:0] eaddr, input logic [DW-1:0] ewd,
                               input logic eerr, input logic [DW-1:0] exa,
                               input logic [DW-1:0] exb);
      vec_t v;
      v.ra = ra; v.wa = wa; v.aa = aa; v.da = da;
      v.rb = rb; v.wb = wb; v.ab = ab; v.db = db;
      v.ep = ep; v.erd = erd; v.ewr = ewr; v.eaddr = eaddr; v.ewd = ewd;
      v.eerr = eerr; v.exa = exa; v.exb = exb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input vec_t v);
      req_a = v.ra; we_a = v.wa; addr_a = v.aa; wdata_a = v.da;
      req_b = v.rb; we_b = v.wb; addr_b = v.ab; wdata_b = v.db;
   endtask

   // Runs one transaction window T+1..T+4; inputs are applied just after an edge (cycle T).
   task automatic run_window(input vec_t v, input bit drop, input string tag);
      apply(v);
      for (int c = 1; c <= 4; c++) begin
         @(posedge clock); #1;
         if (c == 1) begin
            chk({tag, " mem_read"},  DW'(mem_read),  DW'(v.erd));
            chk({tag, " mem_write"}, DW'(mem_write), DW'(v.ewr));
            if (v.erd || v.ewr) chk({tag, " mem_address"}, mem_address, v.eaddr);
            if (v.ewr)          chk({tag, " mem_write_data"}, mem_write_data, v.ewd);
            chk({tag, " busy"}, DW'(busy), 32'd1);
            if (drop) begin req_a = 1'b0; req_b = 1'b0; end
         end else if (c == 2) begin
            chk({tag, " strobes idle"}, DW'({mem_read, mem_write}), 32'd0);
            chk({tag, " early done"}, DW'({done_a, done_b}), 32'd0);
         end else if (c == 3) begin
            chk({tag, " done_a"}, DW'(done_a), DW'(!v.ep));
            chk({tag, " done_b"}, DW'(done_b), DW'(v.ep));
            chk({tag, " err_a"},  DW'(err_a),  DW'(!v.ep && v.eerr));
            chk({tag, " err_b"},  DW'(err_b),  DW'(v.ep && v.eerr));
            chk({tag, " rdata_a"}, rdata_a, v.exa);
            chk({tag, " rdata_b"}, rdata_b, v.exb);
         end else begin
            chk({tag, " done cleared"}, DW'({done_a, done_b}), 32'd0);
            chk({tag, " busy idle"}, DW'(busy), 32'd0);
         end
      end
   endtask

   initial begin
      vec_t idle_v;
      for (int i = 0; i < 32; i++) mem[i] = DW'(i);
      mem_result = '0;
      idle_v = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0);
      apply(idle_v);

      //               ra wa aa           da            rb wb ab           db            ep rd wr eaddr  ewd           err exa           exb
      vecs[0]  = mk(1, 0, 32'd5,       0,            0, 0, 0,           0,            0, 1, 0, 32'd5, 0,            0, 32'd5,        32'd0);
      vecs[1]  = mk(0, 0, 0,           0,            1, 1, 32'd7,       32'hDEADBEEF, 1, 0, 1, 32'd7, 32'hDEADBEEF, 0, 32'd5,        32'd0);
      vecs[2]  = mk(1, 0, 32'd7,       0,            0, 0, 0,           0,            0, 1, 0, 32'd7, 0,            0, 32'hDEADBEEF, 32'd0);
      vecs[3]  = mk(1, 0, 32'd12,      0,            1, 0, 32'd11,      0,            1, 1, 0, 32'd11,0,            0, 32'hDEADBEEF, 32'd11);
      vecs[4]  = mk(1, 0, 32'd12,      0,            1, 0, 32'd13,      0,            0, 1, 0, 32'd12,0,            0, 32'd12,       32'd11);
      vecs[5]  = mk(1, 0, 32'd14,      0,            1, 0, 32'd13,      0,            1, 1, 0, 32'd13,0,            0, 32'd12,       32'd13);
      vecs[6]  = mk(1, 0, 32'd14,      0,            1, 0, 32'd15,      0,            0, 1, 0, 32'd14,0,            0, 32'd14,       32'd13);
      vecs[7]  = mk(1, 0, 32'd40,      0,            0, 0, 0,           0,            0, 0, 0, 0,     0,            1, 32'd14,       32'd13);
      vecs[8]  = mk(0, 0, 0,           0,            1, 0, 32'h80000001,0,            1, 0, 0, 0,     0,            1, 32'd14,       32'd13);
      vecs[9]  = mk(1, 1, 32'd31,      32'h12345678, 0, 0, 0,           0,            0, 0, 1, 32'd31,32'h12345678, 0, 32'd14,       32'd13);
      vecs[10] = mk(0, 0, 0,           0,            1, 0, 32'd31,      0,            1, 1, 0, 32'd31,0,            0, 32'd14,       32'h12345678);
      vecs[11] = mk(1, 1, 32'd32,      32'h55555555, 0, 0, 0,           0,            0, 0, 0, 0,     0,            1, 32'd14,       32'h12345678);

      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      chk("reset busy",    DW'(busy), 32'd0);
      chk("reset strobes", DW'({mem_read, mem_write}), 32'd0);
      chk("reset done",    DW'({done_a, done_b, err_a, err_b}), 32'd0);
      chk("reset rdata_a", rdata_a, 32'd0);
      chk("reset rdata_b", rdata_b, 32'd0);
      chk("reset mem_address", mem_address, 32'd0);

      // Back-to-back table vectors; contention vectors 3..6 run with both requests held.
      for (int i = 0; i < 12; i++) run_window(vecs[i], 1'b0, $sformatf("vec%0d", i));
      apply(idle_v);

      // Request dropped right after acceptance still completes, and nothing follows.
      run_window(mk(1,0,32'd3,0, 0,0,0,0, 0,1,0,32'd3,0,0,32'd3,32'h12345678), 1'b1, "drop");
      for (int c = 0; c < 4; c++) begin
         @(posedge clock); #1;
         chk("drop no restart", DW'({busy, mem_read, mem_write, done_a}), 32'd0);
      end

      // Reset during WAIT of a port B read aborts it; next tie goes to A.
      apply(mk(0,0,0,0, 1,0,32'd9,0, 0,0,0,0,0,0,0,0));
      @(posedge clock); #1;
      chk("abort strobe", DW'(mem_read), 32'd1);
      @(posedge clock); #1;   // WAIT
      reset = 1'b1;
      @(posedge clock); #1;
      chk("abort busy",    DW'(busy), 32'd0);
      chk("abort strobes", DW'({mem_read, mem_write}), 32'd0);
      chk("abort done_b",  DW'(done_b), 32'd0);
      chk("abort rdata_b", rdata_b, 32'd0);
      @(posedge clock); #1;
      chk("abort held done_b", DW'({done_b, busy}), 32'd0);
      reset = 1'b0;
      run_window(mk(1,0,32'd20,0, 1,0,32'd21,0, 0,1,0,32'd20,0,0,32'd20,32'd0), 1'b0, "post_reset_tie");
      apply(idle_v);
      repeat (2) @(posedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected end before 100000");
      $fatal(1, "timeout");
   end

endmodule
